jacobi_sequencer: RTL and testbench

Host-side bus master placed directly upstream of the Jacobi control/array on the global bus (RD, WR, Addr, DataIn, DataOut).

---
 rtl/jacobi_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_jacobi_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jacobi_sequencer.sv
// ---------------------------------------------------------------------------
// jacobi_sequencer : bus master that loads the Jacobi scan chain, arms the
// iteration counter, polls it to zero and unloads the results as a stream.
// Optional: JACOBI_SEQ_CHECKSUM_EN adds a running Checksum output.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jacobi_sequencer #(
  parameter int WIDTH   = 8,
  parameter int CWIDTH  = 8,
  parameter int IDWIDTH = 8,
  parameter int ADDRW   = 32,
  parameter int DATAW   = 32,
  parameter logic [IDWIDTH-1:0] CTRL_ID = 8'hFE,
  parameter logic [IDWIDTH-1:0] SCAN_ID = 8'hFF,
  parameter int NWIDTH  = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [NWIDTH-1:0] NumNodes,
  input  logic [CWIDTH-1:0] Iter,
  input  logic              InValid,
  output logic              InReady,
  input  logic [WIDTH-1:0]  InData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [WIDTH-1:0]  OutData,
  output logic              Busy,
  output logic              Done,
`ifdef JACOBI_SEQ_CHECKSUM_EN
  output logic [WIDTH+NWIDTH-1:0] Checksum,
`endif
  output logic              BusRD,
  output logic              BusWR,
  output logic [ADDRW-1:0]  BusAddr,
  output logic [DATAW-1:0]  BusDataOut,
  input  logic [DATAW-1:0]  BusDataIn
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ARM    = 3'd2,
    S_POLL   = 3'd3,
    S_GAP    = 3'd4,
    S_UNLOAD = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  localparam logic [ADDRW-1:0] c_scan_addr = {{(ADDRW-IDWIDTH){1'b0}}, SCAN_ID};
  localparam logic [ADDRW-1:0] c_ctrl_addr = {{(ADDRW-IDWIDTH){1'b0}}, CTRL_ID};

  state_t              state_q, state_d;
  logic [NWIDTH-1:0]   num_q, num_d;
  logic [CWIDTH-1:0]   iter_q, iter_d;
  logic [NWIDTH-1:0]   idx_q, idx_d;
  logic                bus_rd_q, bus_rd_d;
  logic                bus_wr_q, bus_wr_d;
  logic [ADDRW-1:0]    bus_addr_q, bus_addr_d;
  logic [DATAW-1:0]    bus_data_q, bus_data_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic                done_q, done_d;
  logic                in_ready;
  logic                unused_bits;

  assign unused_bits = &{1'b0, BusDataIn};
  assign in_ready    = (state_q == S_LOAD) && (idx_q < num_q);

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    iter_d      = iter_q;
    idx_d       = idx_q;
    bus_rd_d    = 1'b0;
    bus_wr_d    = 1'b0;
    bus_addr_d  = '0;
    bus_data_d  = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          num_d   = NumNodes;
          iter_d  = Iter;
          idx_d   = '0;
          state_d = (NumNodes == '0) ? S_FINISH : S_LOAD;
        end
      end
      S_LOAD: begin
        // The last write is on the bus in the cycle where idx reaches num.
        if (InValid && in_ready) begin
          bus_wr_d   = 1'b1;
          bus_addr_d = c_scan_addr;
          bus_data_d = {{(DATAW-WIDTH){1'b0}}, InData};
          idx_d      = idx_q + 1'b1;
        end else if (idx_q == num_q) begin
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (iter_q == '0) begin
          state_d = S_GAP;
        end else begin
          bus_wr_d   = 1'b1;
          bus_addr_d = c_ctrl_addr;
          bus_data_d = {{(DATAW-CWIDTH){1'b0}}, iter_q};
          state_d    = S_POLL;
        end
      end
      S_POLL: begin
        if (bus_rd_q && (BusDataIn[CWIDTH-1:0] == '0)) begin
          state_d = S_GAP;
        end else begin
          bus_rd_d   = 1'b1;
          bus_addr_d = c_ctrl_addr;
        end
      end
      S_GAP: begin
        // Bus is idle this cycle; the first scan read is registered here.
        bus_rd_d   = 1'b1;
        bus_addr_d = c_scan_addr;
        idx_d      = {{(NWIDTH-1){1'b0}}, 1'b1};
        state_d    = S_UNLOAD;
      end
      S_UNLOAD: begin
        if (bus_rd_q) begin
          out_data_d  = BusDataIn[WIDTH-1:0];
          out_valid_d = 1'b1;
        end else if (out_valid_q) begin
          if (OutReady) begin
            out_valid_d = 1'b0;
          end
        end else if (idx_q < num_q) begin
          bus_rd_d   = 1'b1;
          bus_addr_d = c_scan_addr;
          idx_d      = idx_q + 1'b1;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      num_q       <= '0;
      iter_q      <= '0;
      idx_q       <= '0;
      bus_rd_q    <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      iter_q      <= iter_d;
      idx_q       <= idx_d;
      bus_rd_q    <= bus_rd_d;
      bus_wr_q    <= bus_wr_d;
      bus_addr_q  <= bus_addr_d;
      bus_data_q  <= bus_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

`ifdef JACOBI_SEQ_CHECKSUM_EN
  logic [WIDTH+NWIDTH-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if ((state_q == S_IDLE) && Start) begin
      checksum_d = '0;
    end else if (out_valid_q && OutReady) begin
      checksum_d = checksum_q + {{NWIDTH{1'b0}}, out_data_q};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign Checksum = checksum_q;
`endif

  assign InReady    = in_ready;
  assign OutValid   = out_valid_q;
  assign OutData    = out_data_q;
  assign Busy       = (state_q != S_IDLE);
  assign Done       = done_q;
  assign BusRD      = bus_rd_q;
  assign BusWR      = bus_wr_q;
  assign BusAddr    = bus_addr_q;
  assign BusDataOut = bus_data_q;

endmodule

`default_nettype wire

// File: tb/tb_jacobi_sequencer.sv
// ---------------------------------------------------------------------------
// tb_jacobi_sequencer : directed bench with a 4-node scan chain and
// decrementing iteration counter model on the global bus.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_jacobi_sequencer;

  localparam int W  = 8;
  localparam int CW = 8;
  localparam int NW = 10;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          Clk;
  logic          Reset;
  logic          Start;
  logic [NW-1:0] NumNodes;
  logic [CW-1:0] Iter;
  logic          InValid;
  logic          InReady;
  logic [W-1:0]  InData;
  logic          OutValid;
  logic          OutReady;
  logic [W-1:0]  OutData;
  logic          Busy;
  logic          Done;
  logic          BusRD;
  logic          BusWR;
  logic [AW-1:0] BusAddr;
  logic [DW-1:0] BusDataOut;
  logic [DW-1:0] BusDataIn;
`ifdef JACOBI_SEQ_CHECKSUM_EN
  logic [W+NW-1:0] Checksum;
`endif

  jacobi_sequencer dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .NumNodes   (NumNodes),
    .Iter       (Iter),
    .InValid    (InValid),
    .InReady    (InReady),
    .InData     (InData),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .OutData    (OutData),
    .Busy       (Busy),
    .Done       (Done),
`ifdef JACOBI_SEQ_CHECKSUM_EN
    .Checksum   (Checksum),
`endif
    .BusRD      (BusRD),
    .BusWR      (BusWR),
    .BusAddr    (BusAddr),
    .BusDataOut (BusDataOut),
    .BusDataIn  (BusDataIn)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Peripheral model: 4-node FIFO scan chain plus iteration counter.
  logic [7:0] chain [0:3];
  logic [7:0] ctrl_cnt;

  initial begin
    for (int i = 0; i < 4; i++) chain[i] = 8'd0;
    ctrl_cnt = 8'd0;
  end

  assign BusDataIn = !BusRD ? 32'd0 :
                     (BusAddr == 32'hFE) ? {24'd0, ctrl_cnt} :
                     (BusAddr == 32'hFF) ? {24'd0, chain[3]} : 32'd0;

  always @(posedge Clk) begin
    if (BusWR && BusAddr == 32'hFF) begin
      for (int i = 3; i > 0; i--) chain[i] <= chain[i-1];
      chain[0] <= BusDataOut[7:0];
    end
    if (BusRD && BusAddr == 32'hFF) begin
      for (int i = 3; i > 0; i--) chain[i] <= chain[i-1];
      chain[0] <= 8'd0;
    end
    if (BusWR && BusAddr == 32'hFE) ctrl_cnt <= BusDataOut[7:0];
    if (BusRD && BusAddr == 32'hFE && ctrl_cnt != 8'd0) ctrl_cnt <= ctrl_cnt - 8'd1;
  end

  // Bus monitor, sampled mid-cycle.
  bit          mon_clr;
  int          cyc, scan_wr, ctrl_wr, poll_rd, scan_rd, done_cnt, busy_cyc;
  int          idle_viol, wr_bad, rd_viol, bus_cyc, last_poll_cyc, first_scan_cyc;
  logic [31:0] ctrl_data;
  logic [31:0] poll_vals [0:15];
  bit          hs_prev;
  logic [31:0] hs_data;

  initial begin
    cyc = 0; mon_clr = 1'b0; hs_prev = 1'b0; hs_data = 32'd0; ctrl_data = 32'd0;
    scan_wr = 0; ctrl_wr = 0; poll_rd = 0; scan_rd = 0; done_cnt = 0; busy_cyc = 0;
    idle_viol = 0; wr_bad = 0; rd_viol = 0; bus_cyc = 0; last_poll_cyc = 0; first_scan_cyc = 0;
  end

  always @(negedge Clk) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      scan_wr <= 0; ctrl_wr <= 0; poll_rd <= 0; scan_rd <= 0; done_cnt <= 0;
      busy_cyc <= 0; idle_viol <= 0; wr_bad <= 0; rd_viol <= 0; ctrl_data <= 32'd0;
    end else begin
      if (!Busy && (BusRD || BusWR)) idle_viol <= idle_viol + 1;
      if (BusRD || BusWR) bus_cyc <= bus_cyc + 1;
      if (BusWR && BusAddr == 32'hFF) begin
        scan_wr <= scan_wr + 1;
        if (!(hs_prev && BusDataOut == hs_data)) wr_bad <= wr_bad + 1;
      end
      if (BusWR && BusAddr == 32'hFE) begin
        ctrl_wr   <= ctrl_wr + 1;
        ctrl_data <= BusDataOut;
      end
      if (BusRD && BusAddr == 32'hFE) begin
        if (poll_rd < 16) poll_vals[poll_rd] <= BusDataIn;
        poll_rd       <= poll_rd + 1;
        last_poll_cyc <= cyc;
      end
      if (BusRD && BusAddr == 32'hFF) begin
        if (scan_rd == 0) first_scan_cyc <= cyc;
        scan_rd <= scan_rd + 1;
        if (OutValid) rd_viol <= rd_viol + 1;
      end
      if (Done) done_cnt <= done_cnt + 1;
      if (Busy) busy_cyc <= busy_cyc + 1;
    end
    hs_prev <= InValid && InReady;
    hs_data <= {24'd0, InData};
  end

  int checks, errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  logic [7:0]  in_vals  [0:7];
  logic [7:0]  out_vals [0:7];
  int          out_cnt, done_lat, hold_bad;
  bit          timed_out, busy_at_done;
  logic [31:0] csum_at_done;

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge Clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic run_job(input int n, input int it, input bit toggle, input int hold,
                         input bit abort_poll);
    int  in_idx, held;
    bit  pend;
    logic [7:0] pend_data;
    clear_mon();
    @(posedge Clk); #1;
    Start = 1'b1; NumNodes = NW'(n); Iter = CW'(it);
    @(posedge Clk); #1;
    Start = 1'b0;
    in_idx = 0; held = 0; pend = 1'b0; pend_data = 8'd0;
    out_cnt = 0; done_lat = 0; hold_bad = 0; timed_out = 1'b1;
    busy_at_done = 1'b0; csum_at_done = 32'd0;
    for (int k = 1; k <= 3000; k++) begin
      InValid  = (in_idx < n) && (!toggle || (k % 2 == 1));
      InData   = (in_idx < 8) ? in_vals[in_idx] : 8'd0;
      OutReady = (held >= hold);
      @(negedge Clk);
      if (InValid && InReady) in_idx++;
      if (OutValid) begin
        if (pend && OutData !== pend_data) hold_bad++;
        if (OutReady) begin
          if (out_cnt < 8) out_vals[out_cnt] = OutData;
          out_cnt++;
          pend = 1'b0;
        end else begin
          pend = 1'b1; pend_data = OutData; held++;
        end
      end
      if (Done) begin
        done_lat = k; timed_out = 1'b0; busy_at_done = Busy;
`ifdef JACOBI_SEQ_CHECKSUM_EN
        csum_at_done = 32'(Checksum);
`endif
        break;
      end
      if (abort_poll && poll_rd >= 2) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge Clk); #1;
    end
    InValid = 1'b0; OutReady = 1'b0;
    check("job_completes", {31'd0, timed_out}, 32'd0);
  endtask

  int saved_bus;

  initial begin
    checks = 0; errors = 0;
    Reset = 1'b1; Start = 1'b0; NumNodes = '0; Iter = '0;
    InValid = 1'b0; InData = '0; OutReady = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_busrd",   {31'd0, BusRD}, 0);
    check("rst_buswr",   {31'd0, BusWR}, 0);
    check("rst_busaddr", BusAddr, 0);
    check("rst_busdata", BusDataOut, 0);
    check("rst_inready", {31'd0, InReady}, 0);
    check("rst_outvalid",{31'd0, OutValid}, 0);
    check("rst_outdata", {24'd0, OutData}, 0);
    check("rst_busy",    {31'd0, Busy}, 0);
    check("rst_done",    {31'd0, Done}, 0);
`ifdef JACOBI_SEQ_CHECKSUM_EN
    check("rst_checksum", 32'(Checksum), 0);
`endif
    @(posedge Clk); #1 Reset = 1'b0;
    repeat (2) @(posedge Clk); #1;

    // 1: Iter=0 pass-through
    in_vals[0] = 8'd10; in_vals[1] = 8'd20; in_vals[2] = 8'd30; in_vals[3] = 8'd40;
    run_job(4, 0, 1'b0, 0, 1'b0);
    @(negedge Clk);
    check("t1_scan_wr", scan_wr, 4);
    check("t1_ctrl_wr", ctrl_wr, 0);
    check("t1_poll_rd", poll_rd, 0);
    check("t1_scan_rd", scan_rd, 4);
    check("t1_out_cnt", out_cnt, 4);
    for (int i = 0; i < 4; i++) check("t1_out_val", {24'd0, out_vals[i]}, 32'(10 * (i + 1)));
    check("t1_done_cnt", done_cnt, 1);
    check("t1_busy_at_done", {31'd0, busy_at_done}, 0);
    check("t1_wr_data", wr_bad, 0);
    check("t1_idle_bus", idle_viol, 0);
`ifdef JACOBI_SEQ_CHECKSUM_EN
    check("t6_checksum", csum_at_done, 100);
`endif
    repeat (3) @(posedge Clk); #1;

    // 2: Iter=3 with polling
    in_vals[0] = 8'd7; in_vals[1] = 8'd9; in_vals[2] = 8'd11; in_vals[3] = 8'd13;
    run_job(4, 3, 1'b0, 0, 1'b0);
    @(negedge Clk);
    check("t2_ctrl_wr",   ctrl_wr, 1);
    check("t2_ctrl_data", ctrl_data, 3);
    check("t2_poll_rd",   poll_rd, 4);
    for (int i = 0; i < 4; i++) check("t2_poll_val", poll_vals[i], 32'(3 - i));
    check("t2_gap", first_scan_cyc - last_poll_cyc - 1, 1);
    check("t2_scan_rd", scan_rd, 4);
    check("t2_out0", {24'd0, out_vals[0]}, 7);
    check("t2_out3", {24'd0, out_vals[3]}, 13);
    check("t2_done_cnt", done_cnt, 1);
    repeat (3) @(posedge Clk); #1;

    // 3: empty job
    run_job(0, 5, 1'b0, 0, 1'b0);
    @(negedge Clk);
    check("t3_done_lat", done_lat, 2);
    check("t3_busy_cyc", busy_cyc, 1);
    check("t3_bus_wr",   scan_wr + ctrl_wr, 0);
    check("t3_bus_rd",   scan_rd + poll_rd, 0);
    check("t3_done_cnt", done_cnt, 1);
    repeat (3) @(posedge Clk); #1;

    // 4: toggling InValid, output stalled 5 cycles
    in_vals[0] = 8'd1; in_vals[1] = 8'd2; in_vals[2] = 8'd3; in_vals[3] = 8'd4;
    run_job(4, 0, 1'b1, 5, 1'b0);
    @(negedge Clk);
    check("t4_scan_wr", scan_wr, 4);
    check("t4_wr_on_hs", wr_bad, 0);
    check("t4_hold", hold_bad, 0);
    check("t4_rd_while_valid", rd_viol, 0);
    check("t4_scan_rd", scan_rd, 4);
    for (int i = 0; i < 4; i++) check("t4_out_val", {24'd0, out_vals[i]}, 32'(i + 1));
    repeat (3) @(posedge Clk); #1;

    // 5: reset during POLL, then a fresh job
    run_job(4, 200, 1'b0, 0, 1'b1);
    @(posedge Clk); #1 Reset = 1'b1;
    @(posedge Clk); #1 Reset = 1'b0;
    @(negedge Clk);
    check("t5_busrd_after_rst", {31'd0, BusRD}, 0);
    check("t5_busy_after_rst",  {31'd0, Busy}, 0);
    saved_bus = bus_cyc;
    repeat (5) @(negedge Clk);
    check("t5_no_bus_after_rst", bus_cyc, saved_bus);
    check("t5_no_done", done_cnt, 0);
    @(posedge Clk); #1;
    in_vals[0] = 8'd5; in_vals[1] = 8'd6; in_vals[2] = 8'd7; in_vals[3] = 8'd8;
    run_job(4, 2, 1'b0, 0, 1'b0);
    @(negedge Clk);
    check("t5_poll_rd", poll_rd, 3);
    check("t5_out_cnt", out_cnt, 4);
    for (int i = 0; i < 4; i++) check("t5_out_val", {24'd0, out_vals[i]}, 32'(i + 5));
    check("t5_done_cnt", done_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
